// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: FSM states, datapath
// select codes and instruction-class indices.
package riscv_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_ERROR  = 3'd7
    } state_t;

    localparam logic [2:0] IMM_R = 3'd0;
    localparam logic [2:0] IMM_I = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_S = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;
    localparam logic [2:0] IMM_J = 3'd5;

    localparam logic [1:0] RD_ALU  = 2'd0;
    localparam logic [1:0] RD_PC4  = 2'd1;
    localparam logic [1:0] RD_IMM  = 2'd2;
    localparam logic [1:0] RD_LOAD = 2'd3;

    localparam logic [1:0] RS1_REG    = 2'd0;
    localparam logic [1:0] RS1_PC     = 2'd1;
    localparam logic [1:0] RS1_PC_JAL = 2'd2;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_JALR  = 2'd2;

    // Class indices double as bit positions in the packed flag vector.
    localparam int NUM_CLS = 9;
    localparam int CLS_W   = 4;
    localparam logic [3:0] CLS_R      = 4'd0;
    localparam logic [3:0] CLS_I      = 4'd1;
    localparam logic [3:0] CLS_STORE  = 4'd2;
    localparam logic [3:0] CLS_BRANCH = 4'd3;
    localparam logic [3:0] CLS_LOAD   = 4'd4;
    localparam logic [3:0] CLS_JAL    = 4'd5;
    localparam logic [3:0] CLS_JALR   = 4'd6;
    localparam logic [3:0] CLS_AUIPC  = 4'd7;
    localparam logic [3:0] CLS_LUI    = 4'd8;

endpackage

// File: rtl/instr_class_enc.sv
// Encodes the decoder's class flags into a class index; cls_vld is high only
// when exactly one flag is set.
module instr_class_enc
    import riscv_ctrl_pkg::*;
(
    input  logic [NUM_CLS-1:0] flags,
    output logic [CLS_W-1:0]   cls_idx,
    output logic               cls_vld
);

    logic [3:0] hot_cnt;

    always_comb begin
        cls_idx = '0;
        hot_cnt = '0;
        for (int i = 0; i < NUM_CLS; i++) begin
            if (flags[i]) begin
                cls_idx = CLS_W'(i);
                hot_cnt = hot_cnt + 4'd1;
            end
        end
        cls_vld = (hot_cnt == 4'd1);
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/exec/mem/wb over one
// shared memory port, with a watchdog that traps a stalled memory.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       r_type,
    input  logic       i_type,
    input  logic       store,
    input  logic       branch,
    input  logic       load,
    input  logic       jal,
    input  logic       jalr,
    input  logic       auipc,
    input  logic       lui,
    input  logic       br_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_sel,
    output logic       reg_write,
    output logic [2:0] imme_sel,
    output logic [1:0] rd_sel,
    output logic [1:0] rs1_sel,
    output logic       err,
    output logic [2:0] state_o
);

    state_t             state_q, state_d;
    logic [CLS_W-1:0]   cls_q, cls_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [CLS_W-1:0]   cls_idx;
    logic               cls_vld;
    logic               timeout;

    logic       req_r, we_r, asel_r, irw_r, pcw_r, rw_r;
    logic [1:0] pcs_r, rd_r, rs1_r;
    logic [2:0] imm_r;

    instr_class_enc u_enc (
        .flags   ({lui, auipc, jalr, jal, load, branch, store, i_type, r_type}),
        .cls_idx (cls_idx),
        .cls_vld (cls_vld)
    );

    // The wait that brings the count up to MEM_TIMEOUT is the trapping one.
    assign timeout = (MEM_TIMEOUT != 0) && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            cls_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        cnt_d   = cnt_q;
        req_r   = 1'b0;
        we_r    = 1'b0;
        asel_r  = 1'b0;
        irw_r   = 1'b0;
        pcw_r   = 1'b0;
        rw_r    = 1'b0;
        pcs_r   = PC_PLUS4;
        rd_r    = RD_ALU;
        rs1_r   = RS1_REG;
        imm_r   = IMM_R;

        case (state_q)
            S_FETCH: begin
                req_r = 1'b1;
                if (mem_ready) begin
                    irw_r   = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_ERROR;
                end
            end
            S_DECODE: begin
                if (cls_vld) begin
                    cls_d   = cls_idx;
                    state_d = S_EXEC;
                end else begin
                    state_d = S_ERROR;
                end
            end
            S_EXEC: begin
                case (cls_q)
                    CLS_I, CLS_LOAD, CLS_JALR: imm_r = IMM_I;
                    CLS_STORE:                 imm_r = IMM_S;
                    CLS_BRANCH:                imm_r = IMM_B;
                    CLS_AUIPC, CLS_LUI:        imm_r = IMM_U;
                    CLS_JAL:                   imm_r = IMM_J;
                    default:                   imm_r = IMM_R;
                endcase
                if (cls_q == CLS_AUIPC)
                    rs1_r = RS1_PC;
                else if (cls_q == CLS_JAL)
                    rs1_r = RS1_PC_JAL;
                if (cls_q == CLS_BRANCH) begin
                    pcw_r   = 1'b1;
                    pcs_r   = br_taken ? PC_IMM : PC_PLUS4;
                    state_d = S_FETCH;
                end else if (cls_q == CLS_LOAD || cls_q == CLS_STORE) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                req_r  = 1'b1;
                asel_r = 1'b1;
                we_r   = (cls_q == CLS_STORE);
                if (mem_ready) begin
                    if (cls_q == CLS_STORE) begin
                        pcw_r   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout) begin
                    state_d = S_ERROR;
                end
            end
            S_WB: begin
                rw_r    = 1'b1;
                pcw_r   = 1'b1;
                state_d = S_FETCH;
                case (cls_q)
                    CLS_LOAD: rd_r = RD_LOAD;
                    CLS_JAL:  begin rd_r = RD_PC4; pcs_r = PC_IMM;  end
                    CLS_JALR: begin rd_r = RD_PC4; pcs_r = PC_JALR; end
                    CLS_LUI:  rd_r = RD_IMM;
                    default:  rd_r = RD_ALU;
                endcase
            end
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_ERROR;
        endcase

        // Wait counting restarts with each new memory phase.
        if (state_d != state_q && (state_d == S_FETCH || state_d == S_MEM))
            cnt_d = '0;
        else if (req_r && !mem_ready)
            cnt_d = cnt_q + CNT_W'(1);
    end

    // Reset masks every output combinationally so an aborted request fires nothing.
    assign mem_req   = !rst && req_r;
    assign mem_we    = !rst && we_r;
    assign addr_sel  = !rst && asel_r;
    assign ir_write  = !rst && irw_r;
    assign pc_write  = !rst && pcw_r;
    assign reg_write = !rst && rw_r;
    assign pc_sel    = rst ? 2'b00 : pcs_r;
    assign rd_sel    = rst ? 2'b00 : rd_r;
    assign rs1_sel   = rst ? 2'b00 : rs1_r;
    assign imme_sel  = rst ? 3'b000 : imm_r;
    assign err       = !rst && (state_q == S_ERROR);
    assign state_o   = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with a 4-cycle memory watchdog; every
// output is compared as one packed vector against hand-written expectations.
module tb_multicycle_ctrl;

    localparam logic [8:0] F_R     = 9'h001;
    localparam logic [8:0] F_I     = 9'h002;
    localparam logic [8:0] F_ST    = 9'h004;
    localparam logic [8:0] F_BR    = 9'h008;
    localparam logic [8:0] F_LD    = 9'h010;
    localparam logic [8:0] F_JAL   = 9'h020;
    localparam logic [8:0] F_JALR  = 9'h040;
    localparam logic [8:0] F_AUIPC = 9'h080;
    localparam logic [8:0] F_LUI   = 9'h100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] flags = '0;
    logic       br_taken = 1'b0;
    logic       mem_ready = 1'b0;

    logic       mem_req, mem_we, addr_sel, ir_write, pc_write, reg_write, err;
    logic [1:0] pc_sel, rd_sel, rs1_sel;
    logic [2:0] imme_sel, state_o;
    logic [18:0] obs;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .r_type    (flags[0]),
        .i_type    (flags[1]),
        .store     (flags[2]),
        .branch    (flags[3]),
        .load      (flags[4]),
        .jal       (flags[5]),
        .jalr      (flags[6]),
        .auipc     (flags[7]),
        .lui       (flags[8]),
        .br_taken  (br_taken),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .addr_sel  (addr_sel),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .pc_sel    (pc_sel),
        .reg_write (reg_write),
        .imme_sel  (imme_sel),
        .rd_sel    (rd_sel),
        .rs1_sel   (rs1_sel),
        .err       (err),
        .state_o   (state_o)
    );

    assign obs = {state_o, mem_req, mem_we, addr_sel, ir_write, pc_write,
                  pc_sel, reg_write, imme_sel, rd_sel, rs1_sel, err};

    function automatic logic [18:0] mk(input logic [2:0] st, input logic req, we, asel, irw, pcw,
                                       input logic [1:0] pcs, input logic rw, input logic [2:0] imm,
                                       input logic [1:0] rd, rs1, input logic e);
        return {st, req, we, asel, irw, pcw, pcs, rw, imm, rd, rs1, e};
    endfunction

    task automatic chk(input string tag, input logic [18:0] exp);
        #1;
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input int waits);
        for (int i = 0; i < waits; i++) begin
            mem_ready = 1'b0;
            chk($sformatf("fetch_wait%0d", i), mk(0, 1, 0, 0, 0, 0, 2'd0, 0, 3'd0, 2'd0, 2'd0, 0));
            cyc();
        end
        mem_ready = 1'b1;
        chk("fetch_ir", mk(0, 1, 0, 0, 1, 0, 2'd0, 0, 3'd0, 2'd0, 2'd0, 0));
        cyc();
        mem_ready = 1'b0;
    endtask

    task automatic do_decode(input logic [8:0] f);
        flags = f;
        chk("decode", mk(1, 0, 0, 0, 0, 0, 2'd0, 0, 3'd0, 2'd0, 2'd0, 0));
        cyc();
        flags = '0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        chk("rst_outputs", mk(0, 0, 0, 0, 0, 0, 2'd0, 0, 3'd0, 2'd0, 2'd0, 0));
        cyc();
        rst = 1'b0;
        chk("rst_release", mk(0, 1, 0, 0, 0, 0, 2'd0, 0, 3'd0, 2'd0, 2'd0, 0));
    endtask

    // Classes that finish through WB: flag, exec imme/rs1, wb rd/pc_sel.
    logic [8:0] t_f   [6] = '{F_R, F_I, F_JAL, F_JALR, F_AUIPC, F_LUI};
    logic [2:0] t_imm [6] = '{3'd0, 3'd1, 3'd5, 3'd1, 3'd4, 3'd4};
    logic [1:0] t_rs1 [6] = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0};
    logic [1:0] t_rd  [6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd2};
    logic [1:0] t_pcs [6] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0};

    initial begin
        cyc();
        cyc();
        chk("in_reset", mk(0, 0, 0, 0, 0, 0, 2'd0, 0, 3'd0, 2'd0, 2'd0, 0));
        rst = 1'b0;
        chk("after_reset", mk(0, 1, 0, 0, 0, 0, 2'd0, 0, 3'd0, 2'd0, 2'd0, 0));

        for (int k = 0; k < 6; k++) begin
            do_fetch(0);
            do_decode(t_f[k]);
            chk($sformatf("exec%0d", k), mk(2, 0, 0, 0, 0, 0, 2'd0, 0, t_imm[k], 2'd0, t_rs1[k], 0));
            cyc();
            chk($sformatf("wb%0d", k), mk(4, 0, 0, 0, 0, 1, t_pcs[k], 1, 3'd0, t_rd[k], 2'd0, 0));
            cyc();
            chk($sformatf("refetch%0d", k), mk(0, 1, 0, 0, 0, 0, 2'd0, 0, 3'd0, 2'd0, 2'd0, 0));
        end

        // Load: fetch and MEM waits together exceed the limit, each phase alone does not.
        do_fetch(2);
        do_decode(F_LD);
        chk("ld_exec", mk(2, 0, 0, 0, 0, 0, 2'd0, 0, 3'd1, 2'd0, 2'd0, 0));
        cyc();
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            chk($sformatf("ld_mem%0d", i), mk(3, 1, 0, 1, 0, 0, 2'd0, 0, 3'd0, 2'd0, 2'd0, 0));
            cyc();
        end
        mem_ready = 1'b0;
        chk("ld_wb", mk(4, 0, 0, 0, 0, 1, 2'd0, 1, 3'd0, 2'd3, 2'd0, 0));
        cyc();

        do_fetch(0);
        do_decode(F_ST);
        chk("st_exec", mk(2, 0, 0, 0, 0, 0, 2'd0, 0, 3'd3, 2'd0, 2'd0, 0));
        cyc();
        mem_ready = 1'b1;
        chk("st_mem", mk(3, 1, 1, 1, 0, 1, 2'd0, 0, 3'd0, 2'd0, 2'd0, 0));
        cyc();
        mem_ready = 1'b0;
        chk("st_done", mk(0, 1, 0, 0, 0, 0, 2'd0, 0, 3'd0, 2'd0, 2'd0, 0));

        for (int t = 1; t >= 0; t--) begin
            do_fetch(0);
            do_decode(F_BR);
            br_taken = (t == 1);
            chk($sformatf("br_exec_t%0d", t), mk(2, 0, 0, 0, 0, 1, 2'(t), 0, 3'd2, 2'd0, 2'd0, 0));
            cyc();
            br_taken = 1'b0;
            chk($sformatf("br_done_t%0d", t), mk(0, 1, 0, 0, 0, 0, 2'd0, 0, 3'd0, 2'd0, 2'd0, 0));
        end

        // Two flags at once traps, and nothing but rst leaves ERROR.
        do_fetch(0);
        do_decode(F_JAL | F_LUI);
        for (int i = 0; i < 3; i++) begin
            flags = F_R;
            mem_ready = 1'b1;
            chk($sformatf("err_multi%0d", i), mk(7, 0, 0, 0, 0, 0, 2'd0, 0, 3'd0, 2'd0, 2'd0, 1));
            cyc();
        end
        flags = '0;
        mem_ready = 1'b0;
        pulse_rst();

        do_fetch(0);
        do_decode(9'h000);
        chk("err_none", mk(7, 0, 0, 0, 0, 0, 2'd0, 0, 3'd0, 2'd0, 2'd0, 1));
        pulse_rst();

        // Watchdog: four unanswered fetch cycles trap.
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wd_wait%0d", i), mk(0, 1, 0, 0, 0, 0, 2'd0, 0, 3'd0, 2'd0, 2'd0, 0));
            cyc();
        end
        chk("wd_trap", mk(7, 0, 0, 0, 0, 0, 2'd0, 0, 3'd0, 2'd0, 2'd0, 1));
        pulse_rst();

        // Ready arriving on the fourth wait cycle still completes the fetch.
        do_fetch(3);
        do_decode(F_R);
        cyc();
        cyc();
        chk("wd_tie_done", mk(0, 1, 0, 0, 0, 0, 2'd0, 0, 3'd0, 2'd0, 2'd0, 0));

        // Reset during a store's MEM phase suppresses its write and retire.
        do_fetch(0);
        do_decode(F_ST);
        cyc();
        chk("abort_mem", mk(3, 1, 1, 1, 0, 0, 2'd0, 0, 3'd0, 2'd0, 2'd0, 0));
        cyc();
        mem_ready = 1'b1;
        rst = 1'b1;
        chk("abort_rst", mk(0, 0, 0, 0, 0, 0, 2'd0, 0, 3'd0, 2'd0, 2'd0, 0));
        cyc();
        rst = 1'b0;
        mem_ready = 1'b0;
        chk("abort_fetch", mk(0, 1, 0, 0, 0, 0, 2'd0, 0, 3'd0, 2'd0, 2'd0, 0));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
